// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
//   Shared types for the TinyALU and its command-side requester.
//   - operation_t : ALU opcode encoding (3'b101 and 3'b110 are unused/illegal)
//   - req_state_t : requester FSM states
//   - is_alu_op   : true for opcodes that run the ALU start/done handshake
//   - is_known_op : true for every defined opcode
// -----------------------------------------------------------------------------
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BUSY = 3'd1,
        NOP  = 3'd2,
        RST  = 3'd3,
        RESP = 3'd4
    } req_state_t;

    function automatic logic is_alu_op(input operation_t op);
        case (op)
            add_op, and_op, xor_op, mul_op: is_alu_op = 1'b1;
            default:                        is_alu_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_known_op(input logic [2:0] code);
        is_known_op = (code != 3'b101) && (code != 3'b110);
    endfunction

endpackage

// File: rtl/tinyalu_requester.sv
// -----------------------------------------------------------------------------
// tinyalu_requester
//   Command-side initiator for the TinyALU. Accepts a command on a valid/ready
//   port, drives the ALU A/B/op/start pins, waits for done (or handles no_op,
//   rst_op, illegal codes and timeouts itself) and returns the result on a
//   valid/ready response port.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles start is held without done before abort (>= 2)
//   RST_CYCLES     : cycles alu_rst is held for rst_op / timeout recovery (>= 1)
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake
//   cmd_a, cmd_b, cmd_op       : operands and opcode
//   rsp_valid/rsp_ready        : response handshake
//   rsp_result, rsp_op         : result (0 for non-ALU/aborted) and opcode
//   rsp_timeout                : command aborted because done never came
//   alu_A, alu_B, alu_op       : registered operands/opcode to the ALU
//   alu_start, alu_done        : ALU start/done handshake
//   alu_result                 : ALU result
//   alu_rst                    : active-high ALU reset (reset OR RST state)
//
// Optional build macro TINYALU_REQ_STATS_EN adds saturating counters:
//   stat_cmds     (16b) : responses consumed (rsp_valid & rsp_ready)
//   stat_timeouts (8b)  : timeout aborts
// -----------------------------------------------------------------------------
module tinyalu_requester
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RST_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_timeout,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    output logic [2:0]  alu_op,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
`ifdef TINYALU_REQ_STATS_EN
    output logic [15:0] stat_cmds,
    output logic [7:0]  stat_timeouts,
`endif
    output logic        alu_rst
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_START = RC_W'(RST_CYCLES);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(1);

    req_state_t       state, state_nxt;
    logic [TO_W-1:0]  tmo_cnt;
    logic [RC_W-1:0]  rst_cnt;

    logic             accept;
    logic             rsp_take;
    logic             done_hit;
    logic             tmo_hit;
    operation_t       cmd_opcode;

    assign cmd_opcode = operation_t'(cmd_op);
    assign accept     = cmd_valid && (state == IDLE);
    assign rsp_take   = rsp_ready && (state == RESP);
    assign done_hit   = (state == BUSY) && alu_done;
    // done wins over timeout when both land on the same edge
    assign tmo_hit    = (state == BUSY) && !alu_done && (tmo_cnt == TO_LAST);

    // alu_rst must follow reset combinationally so the ALU is held while the
    // requester itself is in reset.
    assign alu_rst = reset || (state == RST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_start = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (is_alu_op(cmd_opcode)) begin
                        state_nxt = BUSY;
                    end else if (cmd_opcode == no_op) begin
                        state_nxt = NOP;
                    end else if (cmd_opcode == rst_op) begin
                        state_nxt = RST;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            BUSY: begin
                alu_start = 1'b1;
                if (alu_done) begin
                    state_nxt = RESP;
                end else if (tmo_cnt == TO_LAST) begin
                    state_nxt = RST;
                end
            end
            NOP: begin
                alu_start = 1'b1;
                state_nxt = RESP;
            end
            RST: begin
                if (rst_cnt <= RC_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command capture, counters and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op      <= 3'(no_op);
            rsp_result  <= '0;
            rsp_op      <= 3'(no_op);
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
            rst_cnt     <= '0;
        end else begin
            if (accept) begin
                alu_A       <= cmd_a;
                alu_B       <= cmd_b;
                // illegal codes never reach the ALU
                alu_op      <= is_known_op(cmd_op) ? cmd_op : 3'(no_op);
                rsp_op      <= cmd_op;
                rsp_result  <= '0;
                rsp_timeout <= 1'b0;
                rst_cnt     <= RC_START;
            end

            if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (done_hit) begin
                rsp_result <= alu_result;
            end

            if (tmo_hit) begin
                rsp_timeout <= 1'b1;
                rsp_result  <= '0;
                rst_cnt     <= RC_START;
            end

            if (state == RST) begin
                rst_cnt <= rst_cnt - 1'b1;
            end

            if (rsp_take) begin
                rsp_timeout <= 1'b0;
                tmo_cnt     <= '0;
            end
        end
    end

`ifdef TINYALU_REQ_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // -------------------------------------------------------------------------
    // Statistics counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmds     <= '0;
            stat_timeouts <= '0;
        end else begin
            if (rsp_take) begin
                stat_cmds <= sat_inc16(stat_cmds);
            end
            if (tmo_hit) begin
                stat_timeouts <= sat_inc8(stat_timeouts);
            end
        end
    end
`endif

endmodule
